// File: rtl/usrt_tx_fifo.sv
// usrt_tx_fifo: serial transmitter with an internal transmit FIFO.
// The host pushes words through a valid/ready handshake. Each word is framed
// as a start bit, DATA_W data bits (LSB first), an optional parity bit and one
// or two stop bits. Frames go out back-to-back while words remain queued and
// i_Enable is high. Baud rate and mode are captured when a frame starts, so
// changing them mid-frame only affects later frames.
module usrt_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int BAUD_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_Pclk,
  input  logic                          i_Presetn,
  input  logic [BAUD_W-1:0]             i_Baud,
  input  logic                          i_Enable,
  input  logic                          i_Parity_En,
  input  logic                          i_Parity_Odd,
  input  logic                          i_Stop2,
  input  logic                          i_Valid,
  input  logic [DATA_W-1:0]             i_Data,
  output logic                          o_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Level,
  output logic                          o_Tx_Serial,
  output logic                          o_Busy,
  output logic                          o_Done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // Wide enough to index every data bit; also reused to count stop bits.
  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_word;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;          // clocks left in the current bit, minus one
  logic [BAUD_W-1:0] baud_q, baud_d;        // latched reload value, max(i_Baud,1)-1
  logic [BIT_W-1:0]  bit_q, bit_d;          // data bit index, or stop bit index
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic              start_ok;
  logic              start_now;
  logic [BAUD_W-1:0] baud_reload;

  // A divisor of 0 behaves as 1, so both map to a reload value of 0.
  assign baud_reload = (i_Baud == '0) ? '0 : (i_Baud - BAUD_W'(1));
  assign head_word   = mem_q[rd_ptr_q];
  // A start needs a word that was already stored before this edge; there is
  // no fall-through from i_Data straight to the line.
  assign start_ok    = i_Enable && (count_q != '0);

  // FIFO next-state: pointers wrap naturally because the depth is a power of two.
  always_comb begin
    push     = i_Valid && ready_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + LVL_W'(push) - LVL_W'(pop);
    ready_d = (count_d < LVL_W'(FIFO_DEPTH));
  end

  // FIFO storage write; the array carries no reset so it can map to RAM.
  always_ff @(posedge i_Pclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_Data;
    end
  end

  // FIFO pointer, occupancy and ready registers.
  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Frame sequencing: next state, bit timing, line value and frame-start capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    start_now = 1'b0;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (start_ok) begin
          start_now = 1'b1;
        end
      end

      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          bit_d   = '0;
          cnt_d   = baud_q;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = baud_q;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // The next bit is shift_q[1] before the shift takes effect.
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end

      ST_PARITY: begin
        if (cnt_q == '0) begin
          state_d = ST_STOP;
          bit_d   = '0;
          cnt_d   = baud_q;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == '0) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_d = BIT_W'(1);
            cnt_d = baud_q;
            tx_d  = 1'b1;
          end else begin
            // Frame complete: chain straight into the next START if allowed.
            done_d = 1'b1;
            if (start_ok) begin
              start_now = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Common frame start: pop the head word and freeze the mode for this frame.
    if (start_now) begin
      pop       = 1'b1;
      state_d   = ST_START;
      shift_d   = head_word;
      baud_d    = baud_reload;
      cnt_d     = baud_reload;
      par_en_d  = i_Parity_En;
      par_bit_d = (^head_word) ^ i_Parity_Odd;
      stop2_d   = i_Stop2;
      bit_d     = '0;
      tx_d      = 1'b0;
    end
  end

  // Frame state registers; reset abandons any partial frame.
  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign o_Ready     = ready_q;
  assign o_Level     = count_q;
  assign o_Tx_Serial = tx_q;
  assign o_Busy      = (state_q != ST_IDLE);
  assign o_Done      = done_q;

endmodule

// File: tb/tb_usrt_tx_fifo.sv
// Testbench for usrt_tx_fifo: frame-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_usrt_tx_fifo;

  localparam int DW    = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] baud;
  logic          en, pe, po, s2, valid;
  logic [DW-1:0] data;
  logic          ready, tx, busy, done;
  logic [LW-1:0] level;

  // Second instance built with 5-bit data.
  logic          d5_en, d5_valid;
  logic [4:0]    d5_data;
  logic          d5_ready, d5_tx, d5_busy, d5_done;
  logic [LW-1:0] d5_level;

  always #5 clk = ~clk;

  usrt_tx_fifo #(.DATA_W(DW), .BAUD_W(BW), .FIFO_DEPTH(DEPTH)) dut (
    .i_Pclk(clk), .i_Presetn(rst_n), .i_Baud(baud), .i_Enable(en),
    .i_Parity_En(pe), .i_Parity_Odd(po), .i_Stop2(s2), .i_Valid(valid),
    .i_Data(data), .o_Ready(ready), .o_Level(level), .o_Tx_Serial(tx),
    .o_Busy(busy), .o_Done(done)
  );

  usrt_tx_fifo #(.DATA_W(5), .BAUD_W(BW), .FIFO_DEPTH(DEPTH)) dut5 (
    .i_Pclk(clk), .i_Presetn(rst_n), .i_Baud(baud), .i_Enable(d5_en),
    .i_Parity_En(pe), .i_Parity_Odd(po), .i_Stop2(s2), .i_Valid(d5_valid),
    .i_Data(d5_data), .o_Ready(d5_ready), .o_Level(d5_level), .o_Tx_Serial(d5_tx),
    .o_Busy(d5_busy), .o_Done(d5_done)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model (frame level) ----------------
  int unsigned   mq[$];
  bit            m_frame[$];
  bit            m_active = 1'b0;
  bit            m_done   = 1'b0;
  int            m_elapsed = 0;
  int            m_len = 0;
  int            m_baud = 1;
  int            m_sz;
  bit            m_can_push, m_can_start;
  logic [DW-1:0] m_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_frame.delete();
      m_active  = 1'b0;
      m_done    = 1'b0;
      m_elapsed = 0;
    end else begin
      m_sz        = mq.size();
      m_can_push  = (m_sz < DEPTH);
      m_can_start = en && (m_sz > 0);
      m_done      = 1'b0;
      if (m_active) begin
        m_elapsed++;
        if (m_elapsed == m_len) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
      if (!m_active && m_can_start) begin
        m_w = DW'(mq.pop_front());
        m_baud = (baud == 0) ? 1 : int'(baud);
        m_frame.delete();
        m_frame.push_back(1'b0);
        for (int i = 0; i < DW; i++) m_frame.push_back(m_w[i]);
        if (pe) m_frame.push_back(1'(($countones(m_w) % 2) ^ int'(po)));
        m_frame.push_back(1'b1);
        if (s2) m_frame.push_back(1'b1);
        m_len     = m_baud * m_frame.size();
        m_elapsed = 0;
        m_active  = 1'b1;
      end
      if (valid && m_can_push) mq.push_back(int'(data));
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    check("tx",    int'(tx),    m_active ? int'(m_frame[m_elapsed / m_baud]) : 1);
    check("busy",  int'(busy),  int'(m_active));
    check("done",  int'(done),  int'(m_done));
    check("level", int'(level), mq.size());
    check("ready", int'(ready), (mq.size() < DEPTH) ? 1 : 0);
  end

  // ---------------- directed helpers ----------------
  bit sel5 = 1'b0;
  logic cur_tx, cur_busy, cur_done;
  assign cur_tx   = sel5 ? d5_tx   : tx;
  assign cur_busy = sel5 ? d5_busy : busy;
  assign cur_done = sel5 ? d5_done : done;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] w);
    tick();
    valid = 1'b1;
    data  = w;
    tick();
    valid = 1'b0;
  endtask

  // Acts as the far-end receiver: samples mid-bit and times the frame to o_Done.
  task automatic measure(input string tag, input int b, input int dw, input int exp_word,
                         input int exp_par, input int nstop, input int exp_len);
    bit samp[32];
    int n, k, done_at, word, idx;
    k = 0;
    @(negedge clk);
    while (!cur_busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " start"}, int'(cur_busy), 1);
    n = 0;
    done_at = -1;
    while (n < 20000) begin
      if (cur_done) begin
        done_at = n;
        break;
      end
      if ((n % b) == (b / 2) && (n / b) < 32) samp[n / b] = cur_tx;
      @(negedge clk);
      n++;
    end
    check({tag, " len"}, done_at, exp_len);
    check({tag, " startbit"}, int'(samp[0]), 0);
    word = 0;
    for (int i = 0; i < dw; i++) word |= int'(samp[1 + i]) << i;
    check({tag, " data"}, word, exp_word);
    idx = 1 + dw;
    if (exp_par >= 0) begin
      check({tag, " parity"}, int'(samp[idx]), exp_par);
      idx++;
    end
    for (int i = 0; i < nstop; i++) check({tag, " stop"}, int'(samp[idx + i]), 1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || level != 0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " idle"}, int'(busy || level != 0), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dcnt;
    rst_n = 1'b1; baud = 16'd87; en = 1'b0; pe = 1'b0; po = 1'b0; s2 = 1'b0;
    valid = 1'b0; data = '0; d5_en = 1'b0; d5_valid = 1'b0; d5_data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst tx", int'(tx), 1);
    check("rst ready", int'(ready), 1);
    check("rst level", int'(level), 0);
    check("rst busy", int'(busy), 0);
    #3 rst_n = 1'b1;

    // 8N1 / 8E1 / 8O1 / 8N2 on 0x53 at 87 clocks per bit.
    en = 1'b1;
    push(8'h53); measure("8N1", 87, 8, 'h53, -1, 1, 870);
    pe = 1'b1; po = 1'b0;
    push(8'h53); measure("8E1", 87, 8, 'h53, 0, 1, 957);
    po = 1'b1;
    push(8'h53); measure("8O1", 87, 8, 'h53, 1, 1, 957);
    pe = 1'b0; po = 1'b0; s2 = 1'b1;
    push(8'h53); measure("8N2", 87, 8, 'h53, -1, 2, 957);
    s2 = 1'b0;
    wait_idle("after modes");

    // Fill with enable low: five writes, fifth dropped.
    en = 1'b0; baud = 16'd2;
    tick(); valid = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      data = DW'(w);
      tick();
    end
    valid = 1'b0;
    @(negedge clk);
    check("fill level", int'(level), 4);
    check("fill ready", int'(ready), 0);
    tick(); en = 1'b1;
    dcnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("fill dones", dcnt, 4);
    check("fill drained", int'(level), 0);
    check("fill line", int'(tx), 1);

    // Push in the same cycle as a pop with three words queued.
    en = 1'b0;
    tick(); valid = 1'b1;
    data = 8'h11; tick();
    data = 8'h22; tick();
    data = 8'h33; tick();
    valid = 1'b0;
    @(negedge clk);
    check("pp level before", int'(level), 3);
    tick(); en = 1'b1; valid = 1'b1; data = 8'h44;
    tick(); valid = 1'b0;
    @(negedge clk);
    check("pp level after", int'(level), 3);
    check("pp busy", int'(busy), 1);
    wait_idle("pp");

    // 5-bit build: 0x15 in 7 bit periods.
    sel5 = 1'b1; baud = 16'd3; d5_en = 1'b1;
    tick(); d5_valid = 1'b1; d5_data = 5'h15;
    tick(); d5_valid = 1'b0;
    measure("5N1", 3, 5, 'h15, -1, 1, 21);
    sel5 = 1'b0; d5_en = 1'b0;

    // Reset in the middle of DATA with two words still queued.
    baud = 16'd10; en = 1'b1;
    tick(); valid = 1'b1;
    data = 8'hC3; tick();
    data = 8'h3C; tick();
    data = 8'h5A; tick();
    valid = 1'b0;
    repeat (25) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid rst tx", int'(tx), 1);
    check("mid rst level", int'(level), 0);
    check("mid rst busy", int'(busy), 0);
    check("mid rst done", int'(done), 0);
    check("mid rst ready", int'(ready), 1);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;
    push(8'hA5); measure("after rst", 10, 8, 'hA5, -1, 1, 100);
    wait_idle("after rst");

    // Divisor 0 behaves as 1: ten-clock frame.
    baud = 16'd0;
    push(8'h96); measure("baud0", 1, 8, 'h96, -1, 1, 10);
    wait_idle("baud0");

    // Random traffic; mode inputs wander mid-frame.
    for (int c = 0; c < 4000; c++) begin
      tick();
      valid = ($urandom_range(0, 2) == 0);
      data  = DW'($urandom);
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) begin
        baud = BW'($urandom_range(0, 4));
        pe   = 1'($urandom);
        po   = 1'($urandom);
        s2   = 1'($urandom);
      end
    end
    tick(); valid = 1'b0; en = 1'b1;
    wait_idle("random drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
